// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 keystream path.
package chacha_pkg;

   typedef logic [31:0] word_t;

   localparam int BLOCK_BYTES = 64;

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      KICK,
      WAIT_CORE,
      SERIALISE,
      WAIT_FULL,
      HANDOFF,
      NEXT,
      FINISH
   } seq_state_t;

endpackage

// File: rtl/keystream_sequencer.sv
// Runs the ChaCha20 core, serialiser and 64-byte buffer once per requested
// block, incrementing the block counter and handing each block to the consumer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start
// CLEAR     | pulse buf_clear
// KICK      | pulse core_start with the current block counter
// WAIT_CORE | waiting for core_done
// SERIALISE | ser_en high, counting ser_valid bytes
// WAIT_FULL | waiting for buf_full, bounded by the full timeout
// HANDOFF   | blk_valid high until blk_ready
// NEXT      | advance block counter and remaining count
// FINISH    | pulse done
module keystream_sequencer #(
   parameter int BLOCK_BYTES  = chacha_pkg::BLOCK_BYTES,
   parameter int NBLK_W       = 16,
   parameter int FULL_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NBLK_W-1:0]   num_blocks,
   input  chacha_pkg::word_t   init_counter,
   input  logic                abort,
   output logic                core_start,
   output chacha_pkg::word_t   core_counter,
   input  logic                core_done,
   output logic                ser_en,
   input  logic                ser_valid,
   output logic                buf_clear,
   input  logic                buf_full,
   output logic                blk_valid,
   input  logic                blk_ready,
   output logic                busy,
   output logic                done,
   output logic                err
);
   import chacha_pkg::*;

   localparam int BC_W = $clog2(BLOCK_BYTES) + 1;
   localparam int TO_W = $clog2(FULL_TIMEOUT + 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLOCK_BYTES - 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(FULL_TIMEOUT - 1);

   seq_state_t        state_q, state_d;
   word_t             ctr_q, ctr_d;
   word_t             core_counter_q, core_counter_d;
   logic [NBLK_W-1:0] rem_q, rem_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic              err_q, err_d;
   logic              core_start_q, core_start_d;
   logic              buf_clear_q, buf_clear_d;
   logic              ser_en_q, ser_en_d;
   logic              blk_valid_q, blk_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d        = state_q;
      ctr_d          = ctr_q;
      rem_d          = rem_q;
      byte_cnt_d     = byte_cnt_q;
      timer_d        = timer_q;
      err_d          = err_q;
      core_counter_d = core_counter_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               rem_d   = num_blocks;
               ctr_d   = init_counter;
               err_d   = 1'b0;
               state_d = (num_blocks == '0) ? FINISH : CLEAR;
            end
         end
         CLEAR: begin
            byte_cnt_d = '0;
            state_d    = KICK;
         end
         KICK: state_d = WAIT_CORE;
         WAIT_CORE: begin
            if (core_done) state_d = SERIALISE;
         end
         SERIALISE: begin
            if (ser_valid) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (byte_cnt_q == BC_LAST) begin
                  timer_d = TO_LOAD;
                  state_d = WAIT_FULL;
               end
            end
         end
         // buf_full wins over the timeout if both land on the last cycle
         WAIT_FULL: begin
            if (buf_full) begin
               state_d = HANDOFF;
            end else if (timer_q == '0) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         HANDOFF: begin
            if (blk_ready) state_d = NEXT;
         end
         NEXT: begin
            rem_d = rem_q - 1'b1;
            ctr_d = ctr_q + 32'd1;
            if (rem_d == '0) begin
               state_d = FINISH;
            end else if (ctr_q == 32'hFFFF_FFFF) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else begin
               state_d = CLEAR;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         err_d   = err_q;
      end

      if (state_d == KICK) core_counter_d = ctr_d;

      // Outputs are registered decodes of the next state so they line up with it.
      buf_clear_d  = (state_d == CLEAR);
      core_start_d = (state_d == KICK);
      ser_en_d     = (state_d == SERIALISE);
      blk_valid_d  = (state_d == HANDOFF);
      done_d       = (state_d == FINISH);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         ctr_q          <= '0;
         core_counter_q <= '0;
         rem_q          <= '0;
         byte_cnt_q     <= '0;
         timer_q        <= '0;
         err_q          <= 1'b0;
         core_start_q   <= 1'b0;
         buf_clear_q    <= 1'b0;
         ser_en_q       <= 1'b0;
         blk_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ctr_q          <= ctr_d;
         core_counter_q <= core_counter_d;
         rem_q          <= rem_d;
         byte_cnt_q     <= byte_cnt_d;
         timer_q        <= timer_d;
         err_q          <= err_d;
         core_start_q   <= core_start_d;
         buf_clear_q    <= buf_clear_d;
         ser_en_q       <= ser_en_d;
         blk_valid_q    <= blk_valid_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign core_start   = core_start_q;
   assign core_counter = core_counter_q;
   assign buf_clear    = buf_clear_q;
   assign ser_en       = ser_en_q;
   assign blk_valid    = blk_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_keystream_sequencer.sv
// Directed bench for keystream_sequencer: block runs, backpressure, counter
// wrap, full timeout, abort, zero-block run and mid-run reset.
module tb_keystream_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_blocks;
   logic [31:0] init_counter;
   logic        abort;
   logic        core_start;
   logic [31:0] core_counter;
   logic        core_done;
   logic        ser_en;
   logic        ser_valid;
   logic        buf_clear;
   logic        buf_full;
   logic        blk_valid;
   logic        blk_ready;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   int n_cs     = 0;
   int n_done   = 0;

   keystream_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_blocks   (num_blocks),
      .init_counter (init_counter),
      .abort        (abort),
      .core_start   (core_start),
      .core_counter (core_counter),
      .core_done    (core_done),
      .ser_en       (ser_en),
      .ser_valid    (ser_valid),
      .buf_clear    (buf_clear),
      .buf_full     (buf_full),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_start) n_cs++;
      if (done) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] nb, input logic [31:0] ic);
      num_blocks   = nb;
      init_counter = ic;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   // Services one block from before KICK through the handoff edge.
   task automatic do_block(input logic [31:0] exp_ctr, input int hold, input bit give_full,
                           output int lat);
      int n = 0;
      while (!core_start && n < 8) begin
         tick();
         n++;
      end
      lat = n;
      check("core_start_seen", 32'(core_start), 32'd1);
      check("core_counter", core_counter, exp_ctr);
      tick();
      check("core_start_pulse", 32'(core_start), 32'd0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("ser_en_on", 32'(ser_en), 32'd1);
      for (int i = 0; i < 64; i++) begin
         ser_valid = 1'b1;
         tick();
         if (i == 62) check("ser_en_63", 32'(ser_en), 32'd1);
      end
      ser_valid = 1'b0;
      check("ser_en_off", 32'(ser_en), 32'd0);
      if (give_full) begin
         buf_full = 1'b1;
         tick();
         buf_full = 1'b0;
         check("blk_valid", 32'(blk_valid), 32'd1);
         for (int i = 0; i < hold; i++) begin
            tick();
            check("blk_valid_hold", 32'(blk_valid), 32'd1);
         end
         blk_ready = 1'b1;
         tick();
         blk_ready = 1'b0;
         check("blk_valid_drop", 32'(blk_valid), 32'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {25'd0, core_start, buf_clear, ser_en, blk_valid, busy, done, err}, 32'd0);
      check({tag, "_ctr"}, core_counter, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cs0, d0;
      rst = 1'b1; start = 1'b0; num_blocks = '0; init_counter = '0; abort = 1'b0;
      core_done = 1'b0; ser_valid = 1'b0; buf_full = 1'b0; blk_ready = 1'b0;
      tick(); tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // single block, counter 5
      cs0 = n_cs; d0 = n_done;
      start_run(16'd1, 32'd5);
      check("buf_clear", 32'(buf_clear), 32'd1);
      check("busy_run", 32'(busy), 32'd1);
      do_block(32'd5, 0, 1'b1, lat);
      check("start_latency", 32'(lat + 1), 32'd2);
      tick();
      check("done_1blk", 32'(done), 32'd1);
      tick();
      check("busy_end_1blk", {30'd0, busy, done}, 32'd0);
      check("cs_count_1blk", 32'(n_cs - cs0), 32'd1);

      // three blocks, backpressure on the second
      cs0 = n_cs; d0 = n_done;
      start_run(16'd3, 32'd0);
      do_block(32'd0, 0, 1'b1, lat);
      do_block(32'd1, 10, 1'b1, lat);
      do_block(32'd2, 0, 1'b1, lat);
      tick();
      check("done_3blk", 32'(done), 32'd1);
      check("err_3blk", 32'(err), 32'd0);
      tick(); tick(); tick();
      check("busy_end_3blk", 32'(busy), 32'd0);
      check("done_count_3blk", 32'(n_done - d0), 32'd1);
      check("cs_count_3blk", 32'(n_cs - cs0), 32'd3);

      // counter wrap stops after the first block
      cs0 = n_cs;
      start_run(16'd2, 32'hFFFF_FFFF);
      do_block(32'hFFFF_FFFF, 0, 1'b1, lat);
      tick();
      check("wrap_done", 32'(done), 32'd1);
      check("wrap_err", 32'(err), 32'd1);
      tick(); tick(); tick(); tick();
      check("wrap_err_sticky", {30'd0, err, busy}, 32'd2);
      check("wrap_cs_count", 32'(n_cs - cs0), 32'd1);

      // buf_full never arrives
      start_run(16'd1, 32'd7);
      check("start_clears_err", 32'(err), 32'd0);
      do_block(32'd7, 0, 1'b0, lat);
      for (int i = 0; i < 15; i++) tick();
      check("timeout_early", {30'd0, err, done}, 32'd0);
      tick();
      check("timeout_err_done", {30'd0, err, done}, 32'd3);
      tick();

      // abort while waiting for the core
      d0 = n_done;
      start_run(16'd2, 32'd9);
      check("abort_start_err", 32'(err), 32'd0);
      tick();
      check("abort_kick", 32'(core_start), 32'd1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", {29'd0, busy, core_start, ser_en}, 32'd0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      tick(); tick();
      check("abort_no_done", 32'(n_done - d0), 32'd0);
      check("abort_core_done_ignored", 32'(ser_en), 32'd0);

      // zero-block run
      cs0 = n_cs;
      start_run(16'd0, 32'd3);
      check("zero_done", 32'(done), 32'd1);
      tick();
      check("zero_end", {30'd0, busy, done}, 32'd0);
      check("zero_no_cs", 32'(n_cs - cs0), 32'd0);

      // synchronous reset in the middle of serialisation
      start_run(16'd1, 32'd4);
      tick();
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      ser_valid = 1'b1;
      tick(); tick(); tick();
      check("pre_rst_ser_en", 32'(ser_en), 32'd1);
      rst = 1'b1;
      tick();
      ser_valid = 1'b0;
      check_all_zero("mid_rst");
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
